// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the req/ack data-memory bus and aligns load data.
// It holds the pipeline on wait states, abandons the access after TIMEOUT cycles, and registers MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EXMEMInstruction,
    input  logic [31:0] EXMEMPCPlus4,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMMemWriteData,
    input  logic [4:0]  EXMEMRegRd,
    input  logic        EXMEMRegWrite,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [2:0]  EXMEMMemWrBits,
    input  logic [1:0]  EXMEMMemRBits,
    input  logic [1:0]  EXMEMMemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        MEMWBRegWrite,
    output logic [4:0]  MEMWBRegRd,
    output logic [31:0] MEMWBWriteData,
    output logic [31:0] MEMWBInstruction,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        bus_err_r;
    logic        misalign_err_r;
    logic        wb_reg_write_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] wb_data_r;
    logic [31:0] wb_instr_r;

    size_t       size_s;
    logic        aligned_s;
    logic        access_s;
    logic        mem_op_s;
    logic        misaligned_s;
    logic        req_s;
    logic        ack_s;
    logic        capture_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;
    logic [31:0] load_data_s;
    logic [31:0] wb_data_s;

    wire [1:0] addr_lo_s = EXMEMALUResult[1:0];
    wire       unsigned_s = EXMEMInstruction[14];

    // Access size: loads win over stores when both strobes are set
    always_comb begin
        size_s = SZ_WORD;
        if (EXMEMMemRead) begin
            case (EXMEMMemRBits)
                2'b01:   size_s = SZ_HALF;
                2'b10:   size_s = SZ_BYTE;
                default: size_s = SZ_WORD;
            endcase
        end else if (EXMEMMemWrite) begin
            case (EXMEMMemWrBits)
                3'b001:  size_s = SZ_BYTE;
                3'b010:  size_s = SZ_HALF;
                default: size_s = SZ_WORD;
            endcase
        end else begin
            size_s = SZ_WORD;
        end
    end

    // Natural alignment check for the selected size
    always_comb begin
        aligned_s = 1'b1;
        case (size_s)
            SZ_BYTE: aligned_s = 1'b1;
            SZ_HALF: aligned_s = ~addr_lo_s[0];
            default: aligned_s = (addr_lo_s == 2'b00);
        endcase
    end

    assign access_s     = EXMEMMemRead | EXMEMMemWrite;
    assign mem_op_s     = access_s & aligned_s;
    assign misaligned_s = access_s & ~aligned_s;
    // Gated by rst so the bus and the stall drop the instant reset asserts
    assign req_s        = rst & mem_op_s & (state_r != DROP);
    assign ack_s        = req_s & dmem_ack;
    assign capture_s    = (~mem_op_s & ~misaligned_s) | ack_s;

    // Store byte enables and lane-replicated write data; loads read the full word
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = EXMEMMemWriteData;
        if (EXMEMMemWrite && !EXMEMMemRead) begin
            case (size_s)
                SZ_BYTE: begin
                    be_s    = 4'b0001 << addr_lo_s;
                    wdata_s = {4{EXMEMMemWriteData[7:0]}};
                end
                SZ_HALF: begin
                    be_s    = addr_lo_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{EXMEMMemWriteData[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = EXMEMMemWriteData;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = EXMEMMemWriteData;
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        byte_lane_s = 8'h00;
        case (addr_lo_s)
            2'b00:   byte_lane_s = dmem_rdata[7:0];
            2'b01:   byte_lane_s = dmem_rdata[15:8];
            2'b10:   byte_lane_s = dmem_rdata[23:16];
            default: byte_lane_s = dmem_rdata[31:24];
        endcase
        half_lane_s = addr_lo_s[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data_s = dmem_rdata;
        case (size_s)
            SZ_BYTE: load_data_s = {{24{byte_lane_s[7] & ~unsigned_s}}, byte_lane_s};
            SZ_HALF: load_data_s = {{16{half_lane_s[15] & ~unsigned_s}}, half_lane_s};
            default: load_data_s = dmem_rdata;
        endcase
    end

    // Write-back source select
    always_comb begin
        wb_data_s = EXMEMALUResult;
        case (EXMEMMemtoReg)
            2'b01:   wb_data_s = load_data_s;
            2'b10:   wb_data_s = EXMEMPCPlus4;
            default: wb_data_s = EXMEMALUResult;
        endcase
    end

    // Wait-state FSM with timeout counter and error pulses
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            cnt_r          <= 8'd0;
            bus_err_r      <= 1'b0;
            misalign_err_r <= 1'b0;
        end else begin
            bus_err_r      <= 1'b0;
            misalign_err_r <= misaligned_s;
            case (state_r)
                IDLE: begin
                    if (req_s && !dmem_ack) begin
                        state_r <= WAIT;
                        cnt_r   <= 8'd1;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (ack_s || !mem_op_s) begin
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end else if (cnt_r == TIMEOUT_CNT) begin
                        state_r   <= DROP;
                        cnt_r     <= 8'd0;
                        bus_err_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                DROP: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB pipeline register; stalled, dropped and misaligned slots become bubbles
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wb_reg_write_r <= 1'b0;
            wb_rd_r        <= 5'd0;
            wb_data_r      <= 32'd0;
            wb_instr_r     <= 32'd0;
        end else if (capture_s) begin
            wb_reg_write_r <= EXMEMRegWrite;
            wb_rd_r        <= EXMEMRegRd;
            wb_data_r      <= wb_data_s;
            wb_instr_r     <= EXMEMInstruction;
        end else begin
            wb_reg_write_r <= 1'b0;
            wb_rd_r        <= 5'd0;
            wb_data_r      <= 32'd0;
            wb_instr_r     <= 32'd0;
        end
    end

    assign dmem_req         = req_s;
    assign dmem_we          = req_s & EXMEMMemWrite & ~EXMEMMemRead;
    assign dmem_addr        = {EXMEMALUResult[31:2], 2'b00};
    assign dmem_be          = be_s;
    assign dmem_wdata       = wdata_s;
    assign mem_stall        = req_s & ~dmem_ack;
    assign MEMWBRegWrite    = wb_reg_write_r;
    assign MEMWBRegRd       = wb_rd_r;
    assign MEMWBWriteData   = wb_data_r;
    assign MEMWBInstruction = wb_instr_r;
    assign misalign_err     = misalign_err_r;
    assign bus_err          = bus_err_r;

endmodule
